lsu_mem_port: RTL and testbench

- Load/store initiator between the CPU execute stage and the byte-strobed data RAM.
- Accepts one load or store request at a time over a valid/ready handshake.
- Drives the RAM's read/write address, enable, strobe and data lanes, then returns a response over a valid/ready handshake.
- For loads, returns the sign- or zero-extended result; flags bad requests with an error bit.

---
 rtl/lsu_mem_port.sv | 231 +++++++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store initiator between the execute stage and a
// byte-strobed data RAM. One request is accepted at a time. It is checked for
// errors, then either sent to the RAM for MEM_LATENCY cycles or answered at
// once with an error. The response waits until the consumer takes it.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned half and
// word accesses. When it is undefined, misaligned accesses go to the RAM,
// which resolves byte lanes from any address.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The request fields must be stable while req_valid is high.
// rsp_rdata and rsp_err are stable while rsp_valid is high and rsp_ready is
// low.
module lsu_mem_port #(
    parameter int MEM_LATENCY = 1,
    parameter int MEM_BYTES   = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    // request channel
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    // response channel
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    // RAM side
    output logic [31:0] mem_read_addr,
    output logic [31:0] mem_write_addr,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [3:0]  mem_read_strb,
    output logic [3:0]  mem_write_strb,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    // debug: current FSM state (0 idle, 1 access, 2 response)
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // latched request
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_wdata;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_cnt;

    // response registers
    logic [31:0] r_rdata;
    logic        r_err;

    // request decode
    logic        w_accept;
    logic [1:0]  w_nbytes_m1;
    logic [32:0] w_last_byte;
    logic        w_size_err;
    logic        w_range_err;
    logic        w_align_err;
    logic        w_req_err;

    // access decode
    logic [3:0]  w_strb;
    logic [31:0] w_load_ext;
    logic        w_access_done;

    assign w_accept = req_valid & req_ready;

    // Classify the incoming request. The last byte index is formed in 33 bits
    // so that an address near 0xFFFFFFFF cannot wrap back into range.
    always_comb begin
        case (req_size)
            2'b00:   w_nbytes_m1 = 2'd0;
            2'b01:   w_nbytes_m1 = 2'd1;
            default: w_nbytes_m1 = 2'd3;
        endcase
        w_last_byte = {1'b0, req_addr} + {31'b0, w_nbytes_m1};
        w_size_err  = (req_size == 2'b11);
        w_range_err = (w_last_byte >= 33'(MEM_BYTES));
`ifdef LSU_MISALIGN_TRAP_EN
        w_align_err = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        w_align_err = 1'b0;
`endif
        w_req_err   = w_size_err | w_range_err | w_align_err;
    end

    // Decode the byte-lane strobe from the latched access size.
    always_comb begin
        case (r_size)
            2'b00:   w_strb = 4'b0001;
            2'b01:   w_strb = 4'b0011;
            2'b10:   w_strb = 4'b1111;
            default: w_strb = 4'b0000;
        endcase
    end

    // Extend the load data. Only the low lanes covered by the strobe are used.
    always_comb begin
        case (r_size)
            2'b00:   w_load_ext = {{24{~r_unsigned & mem_read_data[7]}},
                                   mem_read_data[7:0]};
            2'b01:   w_load_ext = {{16{~r_unsigned & mem_read_data[15]}},
                                   mem_read_data[15:0]};
            default: w_load_ext = mem_read_data;
        endcase
    end

    assign w_access_done = (r_state == S_ACCESS) && (r_cnt == 4'd0);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_req_err ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (w_access_done) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Latch the request. The RAM address register changes only for requests
    // that really reach the RAM, so the address lines keep the last real
    // access while the block is idle or answering an error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_wdata    <= 32'd0;
            r_mem_addr <= 32'd0;
            r_cnt      <= 4'd0;
        end else if (w_accept) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_wdata    <= req_wdata;
            if (!w_req_err) begin
                r_mem_addr <= req_addr;
                r_cnt      <= 4'(MEM_LATENCY - 1);
            end
        end else if ((r_state == S_ACCESS) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Response data and error flag. Load data is captured in the last access
    // cycle. Both registers are cleared when the consumer takes the response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= 32'd0;
            r_err   <= w_req_err;
        end else if (w_access_done) begin
            if (!r_we) begin
                r_rdata <= w_load_ext;
            end
        end else if ((r_state == S_RESP) && rsp_ready) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end
    end

    // FSM outputs: the handshake signals and the RAM controls. The RAM is
    // driven only in ACCESS. The address lines always show the latched
    // address.
    always_comb begin
        req_ready        = rst_n && (r_state == S_IDLE);
        rsp_valid        = (r_state == S_RESP);
        mem_read_addr    = r_mem_addr;
        mem_write_addr   = r_mem_addr;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_read_strb    = 4'b0000;
        mem_write_strb   = 4'b0000;
        mem_write_data   = 32'd0;
        if (r_state == S_ACCESS) begin
            if (r_we) begin
                mem_write_enable = 1'b1;
                mem_write_strb   = w_strb;
                mem_write_data   = r_wdata;
            end else begin
                mem_read_enable  = 1'b1;
                mem_read_strb    = w_strb;
            end
        end
    end

    assign rsp_rdata   = r_rdata;
    assign rsp_err     = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Testbench for lsu_mem_port. A byte-array RAM answers the DUT's memory
// lanes. A separate reference memory and a small model of the access rules
// give the expected response for each request.
module tb_lsu_mem_port;

    localparam int LAT = 3;
    localparam int MB  = 256;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_read_addr, mem_write_addr, mem_write_data, mem_read_data;
    logic        mem_read_enable, mem_write_enable;
    logic [3:0]  mem_read_strb, mem_write_strb;
    logic [1:0]  dbg_state;

    lsu_mem_port #(.MEM_LATENCY(LAT), .MEM_BYTES(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .mem_read_strb(mem_read_strb), .mem_write_strb(mem_write_strb),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .o_dbg_state(dbg_state)
    );

    // RAM written by the DUT, reference memory written by the model
    logic [7:0] ram     [MB];
    logic [7:0] ref_mem [MB];
    logic       ram_init;

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 37 + 90);
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < MB; i++) ram[i] <= pat(i);
        end else if (mem_write_enable) begin
            for (int i = 0; i < 4; i++)
                if (mem_write_strb[i] && (({1'b0, mem_write_addr} + 33'(i)) < 33'(MB)))
                    ram[8'(mem_write_addr + 32'(i))] <= mem_write_data[8*i +: 8];
        end
    end

    always_comb begin
        mem_read_data = 32'd0;
        for (int i = 0; i < 4; i++)
            if (({1'b0, mem_read_addr} + 33'(i)) < 33'(MB))
                mem_read_data[8*i +: 8] = ram[8'(mem_read_addr + 32'(i))];
    end

    // scoreboard
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // reference model of the access rules
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'b11) return 1'b1;
        if (({1'b0, addr} + 33'(nbytes(size))) > 33'(MB)) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if (size == 2'd1 && addr[0]) return 1'b1;
        if (size == 2'd2 && addr[1:0] != 2'b00) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr);
        logic [31:0] v = 32'd0;
        int n = nbytes(size);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[8'(addr + 32'(i))];
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        return v;
    endfunction

    // driver: issue one request, follow it through to its response
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        logic        exp_e;
        logic [31:0] exp_d;
        logic [3:0]  estrb;
        int          en_cnt = 0;
        int          first_v = 0;
        int          t = 0;
        exp_e = model_err(size, addr);
        exp_d = (!we && !exp_e) ? model_load(size, uns, addr) : 32'd0;
        estrb = 4'((1 << nbytes(size)) - 1);
        if (we && !exp_e)
            for (int i = 0; i < nbytes(size); i++) ref_mem[8'(addr + 32'(i))] = wdata[8*i +: 8];
        exp_q.push_back(exp_d);

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        while (!req_ready && t < 20) begin @(negedge clk); t++; end
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;

        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            check("req_ready_busy", 32'(req_ready), 32'd0);
            if (mem_read_enable || mem_write_enable) begin
                en_cnt++;
                if (!exp_e) begin
                    check("rd_en", 32'(mem_read_enable), 32'(!we));
                    check("wr_en", 32'(mem_write_enable), 32'(we));
                    check("rd_strb", 32'(mem_read_strb), we ? 32'd0 : 32'(estrb));
                    check("wr_strb", 32'(mem_write_strb), we ? 32'(estrb) : 32'd0);
                    check("rd_addr", mem_read_addr, addr);
                    check("wr_addr", mem_write_addr, addr);
                    check("wr_data", mem_write_data, we ? wdata : 32'd0);
                end
            end
            if (rsp_valid) begin first_v = c; break; end
        end
        check("en_cycles", 32'(en_cnt), exp_e ? 32'd0 : 32'(LAT));
        check("rsp_cycle", 32'(first_v), exp_e ? 32'd1 : 32'(LAT + 1));
        exp_d = exp_q.pop_front();
        if (first_v != 0) begin
            for (int h = 0; h < hold; h++) begin
                check("hold_valid", 32'(rsp_valid), 32'd1);
                check("hold_rdata", rsp_rdata, exp_d);
                check("hold_en", 32'({mem_read_enable, mem_write_enable}), 32'd0);
                check("hold_ready", 32'(req_ready), 32'd0);
                @(negedge clk);
            end
            check("rsp_rdata", rsp_rdata, exp_d);
            check("rsp_err", 32'(rsp_err), 32'(exp_e));
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            check("rsp_valid_clr", 32'(rsp_valid), 32'd0);
        end
    endtask

    // reset while a store is in ACCESS, then confirm the block recovers
    task automatic reset_mid_store();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h80; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_wr_en", 32'(mem_write_enable), 32'd1);
        rst_n = 1'b0;
        // the RAM takes the write at this edge, since the enable is high
        for (int i = 0; i < 4; i++) ref_mem[8'(32'h80 + 32'(i))] = req_wdata[8*i +: 8];
        @(posedge clk); #1;
        check("rst_en", 32'({mem_read_enable, mem_write_enable}), 32'd0);
        check("rst_strb", 32'({mem_read_strb, mem_write_strb}), 32'd0);
        check("rst_raddr", mem_read_addr, 32'd0);
        check("rst_waddr", mem_write_addr, 32'd0);
        check("rst_wdata", mem_write_data, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            check("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        logic        we, uns;
        logic [1:0]  size;
        logic [31:0] addr;
        rst_n = 1'b0; ram_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
        for (int i = 0; i < MB; i++) ref_mem[i] = pat(i);
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_mem_en", 32'({mem_read_enable, mem_write_enable}), 32'd0);
        check("reset_mem_strb", 32'({mem_read_strb, mem_write_strb}), 32'd0);
        check("reset_mem_addr", mem_read_addr | mem_write_addr, 32'd0);
        check("reset_mem_wdata", mem_write_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; ram_init = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // word store then load
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0);
        // byte store then signed and unsigned byte loads
        do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h00000080, 0);
        do_req(1'b0, 2'd0, 1'b0, 32'h21, 32'd0, 0);
        do_req(1'b0, 2'd0, 1'b1, 32'h21, 32'd0, 0);
        // range boundary, including an address that must not wrap
        do_req(1'b0, 2'd2, 1'b0, 32'd252, 32'd0, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'd253, 32'd0, 0);
        do_req(1'b0, 2'd0, 1'b0, 32'hFFFFFFFF, 32'd0, 0);
        do_req(1'b1, 2'd0, 1'b0, 32'd255, 32'h000000A5, 0);
        // back-pressure held for 5 cycles
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5);
        // reserved size, then a misaligned half
        do_req(1'b0, 2'd3, 1'b0, 32'h40, 32'd0, 0);
        do_req(1'b0, 2'd1, 1'b0, 32'h31, 32'd0, 0);
        do_req(1'b0, 2'd1, 1'b1, 32'h31, 32'd0, 0);
        // reset in the middle of a store, then a normal request
        reset_mid_store();
        do_req(1'b0, 2'd2, 1'b0, 32'h80, 32'd0, 0);

        // random traffic
        for (int n = 0; n < 60; n++) begin
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 9))
                8:       addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
                9:       addr = $urandom;
                default: addr = 32'($urandom_range(0, MB + 3));
            endcase
            do_req(we, size, uns, addr, $urandom, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
